port_rr_arbiter: RTL and testbench
==================================

// Module: port_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one memory-pool port between NUM_REQ requesters.
//  Each grant lasts for one complete burst: from the first beat to the beat with last=1.
//  The grant is a one-hot vector. It drives a my_mux instance that selects the payload.
//  Sits between the read/write request sources and the pool port. Has a registered output stage.
// PARAMETERS
//  NUM_REQ    3   number of requesters; only 3 or 4 are legal (my_mux limit)
//  DATA_WIDTH 48  payload width per requester (addr+ctrl or data)
//  MAX_BEATS  16  forced-rotation limit in accepted beats per grant; 0 disables it
// PORTS
//  clk        in   1                  single clock, all logic rising-edge
//  rst        in   1                  synchronous reset, active-high
//  req_valid  in   NUM_REQ            per-requester beat valid
//  req_last   in   NUM_REQ            per-requester last beat of burst
//  req_data   in   NUM_REQ*DATA_WIDTH packed payload; requester i at [(i+1)*DW-1:i*DW]
//  req_ready  out  NUM_REQ            per-requester beat accept
//  gnt        out  NUM_REQ            one-hot current grant (all-zero when idle)
//  out_valid  out  1                  registered beat valid toward pool port
//  out_data   out  DATA_WIDTH         registered selected payload
//  out_src    out  NUM_REQ            one-hot source of the beat in out_data
//  out_last   out  1                  registered copy of the granted req_last
//  out_ready  in   1                  pool port accepts beat
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge) clears everything:
//   - state=IDLE, gnt=0, ptr=0, beat_cnt=0
//   - out_valid=0, out_data=0, out_src=0, out_last=0
//   - req_ready is 0 while gnt=0
//  FSM IDLE:
//   - if any req_valid, choose the first set bit searching ptr, ptr+1, ... (mod NUM_REQ)
//   - register the one-hot gnt and go to BUSY; arbitration costs 1 cycle, no beat moves in IDLE
//  FSM BUSY:
//   - gnt is held stable
//   - load = ~out_valid | out_ready (a free or draining output register)
//   - req_ready = gnt & {NUM_REQ{load}}
//   - beat accepted when |(req_valid & req_ready)
//   - an accepted beat loads out_data (via my_mux), out_src=gnt, out_last=req_last[g], out_valid=1
//   - on a cycle with out_valid & out_ready and no new accept, out_valid drops to 0
//  Release: end of grant, when an accepted beat has last=1, or beat_cnt+1==MAX_BEATS (if MAX_BEATS!=0).
//   - next cycle: gnt=0, state=IDLE, ptr=index(g)+1 mod NUM_REQ, beat_cnt=0
//   - a forced release does not alter out_last; the requester resumes its burst at its next grant
//   - minimum cost is 2 cycles per grant, so a single-beat burst yields at most 1 beat per 2 cycles
//  Non-granted requesters always see req_ready=0; their req_valid is ignored until arbitrated.
//  Granted requester drops req_valid mid-burst: grant held indefinitely; no timeout.
//  Backpressure: out_ready=0 with out_valid=1 holds out_* and all req_ready low.
//  Simultaneous valid on all requesters with single-beat bursts: grants rotate 0,1,2,(3),0,...
//  beat_cnt saturates at MAX_BEATS-1 width; it is clog2(MAX_BEATS+1) bits.
//  rst asserted mid-burst: the in-flight out beat is discarded; the requester must restart its burst.
// STRUCTURE
//  Shared package/header holds:
//   - state encodings ST_IDLE=1'b0, ST_BUSY=1'b1
//   - legal NUM_REQ range check (elaboration error if not 3/4)
//  Sub-module: my_mux #(DATA_WIDTH, CTRL_WIDTH=NUM_REQ) with input_ctrl=gnt selects the payload.
//  Round-robin pick is a function: double-width rotate of req_valid by ptr, priority encode, rotate back.
// TESTING
//  1 Reset: hold rst 3 cycles with all req_valid=1 -> gnt=0, req_ready=0, out_valid=0, out_data=0.
//  2 Rotation: req_valid=3'b111, all last=1, out_ready=1 -> gnt order 001,010,100,001.
//     One beat every 2 cycles.
//  3 Burst lock: req0 4-beat burst (last on beat 4), req1 valid throughout ->
//     out_src=001 for 4 beats, then 010.
//  4 Backpressure: out_ready=0 for 5 cycles mid-burst -> out_data stable, req_ready=0.
//     No beat lost or duplicated after release.
//  5 Forced rotation: MAX_BEATS=4, req2 20-beat burst, req0 valid -> grant moves to req0
//     after 4 beats of req2, out_last=0 on beat 4.
//  6 Reset mid-burst at beat 2 of 4 -> next cycle out_valid=0, gnt=0, ptr=0;
//     re-arbitration starts from req0.

Source files
------------

// File: rtl/port_rr_arbiter_pkg.sv
// Shared definitions for the round-robin pool-port arbiter.
package port_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int NUM_REQ_MIN = 3;
  localparam int NUM_REQ_MAX = 4;

  // my_mux only supports 3 or 4 select lines
  function automatic bit num_req_legal(input int n);
    return (n >= NUM_REQ_MIN) && (n <= NUM_REQ_MAX);
  endfunction

  // beat counter width; keeps one bit when forced rotation is disabled
  function automatic int cnt_width(input int max_beats);
    return (max_beats > 0) ? $clog2(max_beats + 1) : 1;
  endfunction

endpackage

// File: rtl/port_rr_arbiter_if.sv
// Requester-side and pool-side handshake bundle of the arbiter.
interface port_rr_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 48
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            gnt;
  logic                          out_valid;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [NUM_REQ-1:0]            out_src;
  logic                          out_last;
  logic                          out_ready;

  // environment side: requesters plus pool port
  modport master (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, gnt, out_valid, out_data, out_src, out_last
  );

  // arbiter side
  modport slave (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, gnt, out_valid, out_data, out_src, out_last
  );
endinterface

// File: rtl/port_rr_arbiter_my_mux.sv
// One-hot AND-OR payload selector; an all-zero select gives zero.
module my_mux #(
  parameter int DATA_WIDTH = 48,
  parameter int CTRL_WIDTH = 3
) (
  input  logic [CTRL_WIDTH*DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0]            i_ctrl,
  output logic [DATA_WIDTH-1:0]            o_data
);

  // OR together every slice whose select bit is set
  always_comb begin
    o_data = '0;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      if (i_ctrl[i]) o_data = o_data | i_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/port_rr_arbiter.sv
// Burst-granular round-robin arbiter sharing one pool port, registered output.
//   state   | meaning
//   ST_IDLE | no grant; picks the next requester from ptr (1 cycle)
//   ST_BUSY | grant held until a last beat or the beat limit is accepted
module port_rr_arbiter
  import port_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 48,
  parameter int MAX_BEATS  = 16
) (
  input  logic           clk,
  input  logic           rst,
  port_rr_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(MAX_BEATS);

  if (!num_req_legal(NUM_REQ)) begin : g_bad_num_req
    $error("port_rr_arbiter: NUM_REQ must be 3 or 4");
  end

  state_t                r_state, w_state_nxt;
  logic [NUM_REQ-1:0]    r_gnt, w_gnt_nxt;
  logic [PTR_W-1:0]      r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]      r_beat_cnt, w_beat_cnt_nxt;
  logic                  r_out_valid, r_out_last;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [NUM_REQ-1:0]    r_out_src;

  logic                  w_load, w_accept, w_last_g, w_cap, w_release, w_cnt_sat;
  logic [NUM_REQ-1:0]    w_req_ready;
  logic [DATA_WIDTH-1:0] w_mux_data;

  // rotate requests so ptr sits at bit 0, take lowest set bit, rotate back
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr);
    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] back;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   pick;
    dbl  = {req, req} >> ptr;
    rot  = dbl[NUM_REQ-1:0];
    pick = rot & (~rot + 1'b1);
    back = {pick, pick} << ptr;
    return back[2*NUM_REQ-1:NUM_REQ];
  endfunction

  function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

  my_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .CTRL_WIDTH (NUM_REQ)
  ) u_mux (
    .i_data (bus.req_data),
    .i_ctrl (r_gnt),
    .o_data (w_mux_data)
  );

  // a beat may move only when the output register is empty or draining
  assign w_load      = ~r_out_valid | bus.out_ready;
  assign w_req_ready = r_gnt & {NUM_REQ{w_load}};
  assign w_accept    = |(bus.req_valid & w_req_ready);
  assign w_last_g    = |(bus.req_last & r_gnt);
  assign w_cap       = (MAX_BEATS != 0) &&
                       (((CNT_W+1)'(r_beat_cnt) + 1'b1) == (CNT_W+1)'(MAX_BEATS));
  assign w_release   = w_accept & (w_last_g | w_cap);
  assign w_cnt_sat   = (r_beat_cnt == {CNT_W{1'b1}});

  // next-state: arbitrate in IDLE, hold grant in BUSY until release
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_ptr_nxt      = r_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          w_gnt_nxt   = rr_pick(bus.req_valid, r_ptr);
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_release) begin
          w_gnt_nxt      = '0;
          w_state_nxt    = ST_IDLE;
          w_ptr_nxt      = (onehot_idx(r_gnt) == PTR_W'(NUM_REQ-1)) ? '0
                                                                    : onehot_idx(r_gnt) + 1'b1;
          w_beat_cnt_nxt = '0;
        end else if (w_accept && (MAX_BEATS != 0) && !w_cnt_sat) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // FSM, grant, pointer and beat-count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // output register: load on accept, empty once the pool takes the beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_src   <= r_gnt;
      r_out_last  <= w_last_g;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.gnt       = r_gnt;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;
  assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_port_rr_arbiter.sv
// Directed bench for port_rr_arbiter (NUM_REQ=3, DATA_WIDTH=48, MAX_BEATS=4).
module tb_port_rr_arbiter;

  localparam int NR = 3;
  localparam int DW = 48;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  always #5 clk = ~clk;

  port_rr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  port_rr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  int len [NR];
  int beat[NR];
  bit act [NR];
  bit loop_burst[NR];
  logic [51:0] beat_log[$];

  function automatic logic [DW-1:0] pay(input int i, input int b);
    return {8'(i + 1), 40'(b)};
  endfunction

  function automatic logic [51:0] ent(input logic [2:0] src, input logic last,
                                      input int i, input int b);
    return {src, last, pay(i, b)};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    logic [NR-1:0]    v;
    logic [NR-1:0]    l;
    logic [NR*DW-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NR; i++) begin
      v[i] = act[i];
      l[i] = act[i] && (beat[i] == len[i] - 1);
      d[i*DW +: DW] = pay(i, beat[i]);
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.out_ready = rdy;
  endtask

  // one clock: drive, note handshakes before the edge, advance requesters after it
  task automatic run_cycle();
    logic [NR-1:0] acc;
    drive();
    #1;
    acc = bus.req_valid & bus.req_ready;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      beat_log.push_back({bus.out_src, bus.out_last, bus.out_data});
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i] === 1'b1) begin
        beat[i]++;
        if (beat[i] == len[i]) begin
          beat[i] = 0;
          if (!loop_burst[i]) act[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic set_req(input int i, input int n, input bit lp);
    act[i]        = 1'b1;
    len[i]        = n;
    beat[i]       = 0;
    loop_burst[i] = lp;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) begin
      act[i]        = 1'b0;
      len[i]        = 1;
      beat[i]       = 0;
      loop_burst[i] = 1'b0;
    end
    beat_log.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) run_cycle();
    rst = 1'b0;
    beat_log.delete();
  endtask

  logic [51:0] exp_log[6];

  initial begin
    rdy = 1'b1;
    clear_model();

    // reset held with every requester asking
    for (int i = 0; i < NR; i++) set_req(i, 1, 1'b1);
    rst = 1'b1;
    repeat (3) run_cycle();
    check_eq("rst_gnt",       bus.gnt,       0);
    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_data",  bus.out_data,  0);
    check_eq("rst_out_src",   bus.out_src,   0);
    check_eq("rst_out_last",  bus.out_last,  0);
    rst = 1'b0;
    beat_log.delete();

    // rotation with single-beat bursts on all requesters
    for (int k = 0; k < 4; k++) begin
      int g;
      g = k % NR;
      run_cycle();
      check_eq($sformatf("rot_gnt%0d", k),    bus.gnt,       64'(1 << g));
      check_eq($sformatf("rot_ovld_lo%0d", k), bus.out_valid, 0);
      run_cycle();
      check_eq($sformatf("rot_gnt_idle%0d", k), bus.gnt,      0);
      check_eq($sformatf("rot_ovld%0d", k),   bus.out_valid, 1);
      check_eq($sformatf("rot_src%0d", k),    bus.out_src,   64'(1 << g));
      check_eq($sformatf("rot_data%0d", k),   bus.out_data,  pay(g, 0));
    end

    // burst lock: req0 four beats, req1 waits
    clear_model();
    do_reset(1);
    set_req(0, 4, 1'b0);
    set_req(1, 1, 1'b0);
    repeat (14) run_cycle();
    exp_log[0] = ent(3'b001, 1'b0, 0, 0);
    exp_log[1] = ent(3'b001, 1'b0, 0, 1);
    exp_log[2] = ent(3'b001, 1'b0, 0, 2);
    exp_log[3] = ent(3'b001, 1'b1, 0, 3);
    exp_log[4] = ent(3'b010, 1'b1, 1, 0);
    check_eq("lock_count", beat_log.size(), 5);
    for (int k = 0; k < 5 && k < beat_log.size(); k++)
      check_eq($sformatf("lock_beat%0d", k), beat_log[k], exp_log[k]);

    // backpressure mid-burst
    clear_model();
    do_reset(1);
    set_req(0, 4, 1'b0);
    repeat (3) run_cycle();
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      run_cycle();
      check_eq($sformatf("bp_ovld%0d", k), bus.out_valid, 1);
      check_eq($sformatf("bp_data%0d", k), bus.out_data,  pay(0, 1));
      check_eq($sformatf("bp_rdy%0d", k),  bus.req_ready, 0);
    end
    rdy = 1'b1;
    repeat (10) run_cycle();
    check_eq("bp_count", beat_log.size(), 4);
    for (int k = 0; k < 4 && k < beat_log.size(); k++)
      check_eq($sformatf("bp_beat%0d", k), beat_log[k],
               ent(3'b001, (k == 3) ? 1'b1 : 1'b0, 0, k));

    // forced rotation after MAX_BEATS beats of a long burst
    clear_model();
    do_reset(1);
    set_req(2, 20, 1'b0);
    repeat (2) run_cycle();
    set_req(0, 1, 1'b0);
    repeat (14) run_cycle();
    exp_log[0] = ent(3'b100, 1'b0, 2, 0);
    exp_log[1] = ent(3'b100, 1'b0, 2, 1);
    exp_log[2] = ent(3'b100, 1'b0, 2, 2);
    exp_log[3] = ent(3'b100, 1'b0, 2, 3);
    exp_log[4] = ent(3'b001, 1'b1, 0, 0);
    exp_log[5] = ent(3'b100, 1'b0, 2, 4);
    check_eq("force_enough", (beat_log.size() >= 6) ? 1 : 0, 1);
    for (int k = 0; k < 6 && k < beat_log.size(); k++)
      check_eq($sformatf("force_beat%0d", k), beat_log[k], exp_log[k]);

    // reset in the middle of req1's burst, after ptr has moved off 0
    clear_model();
    do_reset(1);
    set_req(0, 1, 1'b0);
    set_req(1, 4, 1'b0);
    repeat (5) run_cycle();
    check_eq("mid_src",  bus.out_src,  3'b010);
    check_eq("mid_data", bus.out_data, pay(1, 1));
    rst = 1'b1;
    run_cycle();
    check_eq("mrst_ovld", bus.out_valid, 0);
    check_eq("mrst_gnt",  bus.gnt,       0);
    check_eq("mrst_data", bus.out_data,  0);
    check_eq("mrst_rdy",  bus.req_ready, 0);
    rst = 1'b0;
    clear_model();
    set_req(0, 1, 1'b0);
    set_req(1, 4, 1'b0);
    set_req(2, 1, 1'b0);
    run_cycle();
    check_eq("rearb_gnt", bus.gnt, 3'b001);
    run_cycle();
    check_eq("rearb_src",  bus.out_src,  3'b001);
    check_eq("rearb_data", bus.out_data, pay(0, 0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
